// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 33-cycle latency, single-cycle MTHI/MTLO.
module mdu_hilo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             MDU_clk,
    input  logic             MDU_rst_n,
    input  logic             MDU_start,
    input  logic [2:0]       MDU_op,
    input  logic [WIDTH-1:0] MDU_a,
    input  logic [WIDTH-1:0] MDU_b,
    output logic             MDU_busy,
    output logic             MDU_done,
    output logic [WIDTH-1:0] MDU_hi,
    output logic [WIDTH-1:0] MDU_lo
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_a_q, neg_a_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [PW-1:0]      p_q, p_d;

    logic               sgn;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [PW-1:0]      mul_next;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [PW-1:0]      div_next;
    logic [PW-1:0]      prod_fix;
    logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;

    assign MDU_busy = busy_q;
    assign MDU_done = done_q;
    assign MDU_hi   = hi_q;
    assign MDU_lo   = lo_q;

    // Operand conditioning and one iteration of each datapath
    always_comb begin
        sgn   = ~MDU_op[0];
        a_abs = (sgn && MDU_a[WIDTH-1]) ? -MDU_a : MDU_a;
        b_abs = (sgn && MDU_b[WIDTH-1]) ? -MDU_b : MDU_b;

        // Multiply: P = {acc, multiplier}; add multiplicand to acc when LSB set, shift right.
        mul_add  = p_q[0] ? m_q : '0;
        mul_sum  = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, mul_add};
        mul_next = {mul_sum, p_q[WIDTH-1:1]};

        // Divide: P = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
        rem_sh   = {p_q[PW-1:WIDTH], p_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_q};
        div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                   : {rem_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

        prod_fix = neg_q ? -p_q : p_q;
        quot     = p_q[WIDTH-1:0];
        rem      = p_q[PW-1:WIDTH];
        quot_fix = neg_q ? -quot : quot;
        rem_fix  = neg_a_q ? -rem : rem;
    end

    // Next-state and register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        neg_a_d  = neg_a_q;
        m_d      = m_q;
        a_raw_d  = a_raw_q;
        p_d      = p_q;

        case (state_q)
            S_IDLE: begin
                if (MDU_start) begin
                    if (!MDU_op[2]) begin
                        is_div_d = MDU_op[1];
                        neg_a_d  = sgn & MDU_a[WIDTH-1];
                        neg_d    = sgn & (MDU_a[WIDTH-1] ^ MDU_b[WIDTH-1]);
                        m_d      = MDU_op[1] ? b_abs : a_abs;
                        p_d      = {WIDTH'(0), (MDU_op[1] ? a_abs : b_abs)};
                        a_raw_d  = MDU_a;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = S_RUN;
                    end else if (MDU_op == 3'b100) begin
                        hi_d = MDU_a;
                    end else if (MDU_op == 3'b101) begin
                        lo_d = MDU_a;
                    end
                end
            end
            S_RUN: begin
                p_d   = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (m_q == '0) begin
                    // Divide by zero: all-ones quotient, dividend passed through as remainder
                    lo_d = '1;
                    hi_d = a_raw_q;
                end else begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MDU_clk or negedge MDU_rst_n) begin
        if (!MDU_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            m_q      <= '0;
            a_raw_q  <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            neg_a_q  <= neg_a_d;
            m_q      <= m_d;
            a_raw_q  <= a_raw_d;
            p_q      <= p_d;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed corner cases plus randomized ops
// compared against an arithmetic HI/LO reference model.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
        .MDU_clk   (clk),
        .MDU_rst_n (rst_n),
        .MDU_start (start),
        .MDU_op    (op),
        .MDU_a     (a),
        .MDU_b     (b),
        .MDU_busy  (busy),
        .MDU_done  (done),
        .MDU_hi    (hi),
        .MDU_lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Architectural result of one request on the expected HI/LO
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int          q, r;
        case (o)
            3'd0: begin
                p = 64'(longint'($signed(x)) * longint'($signed(y)));
                {exp_hi, exp_lo} = p;
            end
            3'd1: begin
                p = {32'd0, x} * {32'd0, y};
                {exp_hi, exp_lo} = p;
            end
            3'd2: begin
                if (y == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF; exp_hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    exp_lo = 32'h8000_0000; exp_hi = 32'd0;
                end else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    exp_lo = 32'(q); exp_hi = 32'(r);
                end
            end
            3'd3: begin
                if (y == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF; exp_hi = x;
                end else begin
                    exp_lo = x / y; exp_hi = x % y;
                end
            end
            3'd4: exp_hi = x;
            3'd5: exp_lo = x;
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; returns in the done cycle.
    task automatic wait_done(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            if (n == 16) begin
                chk({tag, ".hi_hold"}, {32'd0, hi}, {32'd0, exp_hi});
                chk({tag, ".lo_hold"}, {32'd0, lo}, {32'd0, exp_lo});
            end
            n++;
            step();
        end
        chk({tag, ".busy_cycles"}, 64'(n), 64'd33);
        chk({tag, ".done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
        if (!o[2]) begin
            wait_done(tag);
            model(o, x, y);
        end else begin
            model(o, x, y);
            chk({tag, ".busy"}, {63'd0, busy}, 64'd0);
            chk({tag, ".done"}, {63'd0, done}, 64'd0);
        end
        chk({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            5: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        #12;
        chk("reset.hi", {32'd0, hi}, 64'd0);
        chk("reset.lo", {32'd0, lo}, 64'd0);
        chk("reset.busy", {63'd0, busy}, 64'd0);
        chk("reset.done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset in the middle of a multiply
        run_op("pre_mthi", 3'd4, 32'hAAAA_5555, 32'd0);
        run_op("pre_mtlo", 3'd5, 32'h5A5A_A5A5, 32'd0);
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        step();
        start = 1'b0;
        repeat (9) step();
        #2 rst_n = 1'b0;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        chk("rst_mid.busy", {63'd0, busy}, 64'd0);
        chk("rst_mid.done", {63'd0, done}, 64'd0);
        chk("rst_mid.hi", {32'd0, hi}, 64'd0);
        chk("rst_mid.lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            step();
            if (done || busy) seen++;
        end
        chk("rst_mid.no_done", 64'(seen), 64'd0);
        chk("rst_mid.hi_after", {32'd0, hi}, 64'd0);

        // Directed corner cases, issued back-to-back
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg.hi_const", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        chk("mult_neg.lo_const", {32'd0, lo}, {32'd0, 32'hFFFF_FFEB});
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max.hi_const", {32'd0, hi}, {32'd0, 32'hFFFF_FFFE});
        chk("multu_max.lo_const", {32'd0, lo}, 64'd1);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg.lo_const", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});
        chk("div_neg.hi_const", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        run_op("divu_zero", 3'd3, 32'd7, 32'd0);
        chk("divu_zero.lo_const", {32'd0, lo}, {32'd0, 32'hFFFF_FFFF});
        chk("divu_zero.hi_const", {32'd0, hi}, 64'd7);
        run_op("div_zero_s", 3'd2, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.lo_const", {32'd0, lo}, {32'd0, 32'h8000_0000});
        chk("div_ovf.hi_const", {32'd0, hi}, 64'd0);
        step();
        chk("idle.done_drop", {63'd0, done}, 64'd0);

        // MTHI held high through a multiply: ignored while busy, taken in the done cycle
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        step();
        op = 3'd4; a = 32'h0000_1234;
        wait_done("mthi_busy");
        model(3'd0, 32'd3, 32'd5);
        chk("mthi_busy.hi_ignored", {32'd0, hi}, {32'd0, exp_hi});
        chk("mthi_busy.lo", {32'd0, lo}, {32'd0, exp_lo});
        step();
        start = 1'b0;
        model(3'd4, 32'h0000_1234, 32'd0);
        chk("mthi_done.hi", {32'd0, hi}, {32'd0, 32'h0000_1234});
        chk("mthi_done.busy", {63'd0, busy}, 64'd0);
        chk("mthi_done.done", {63'd0, done}, 64'd0);

        // Randomized mix, including no-op encodings
        for (int i = 0; i < 48; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
